// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, geometry, FSM states and slot-index helper for conv_engine
package conv_pkg;

    localparam int WORD_LENGTH        = 8;
    localparam int DOUBLE_WORD_LENGTH = 16;
    localparam int KERNEL_SIZE        = 5;
    localparam int IMAGE_SIZE         = 28;
    localparam int OUT_SIZE           = IMAGE_SIZE - KERNEL_SIZE + 1;

    // LOAD counts incoming pixels, DRAIN waits for the last window to land
    // in its slot, DONE freezes the output map until reset.
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    // Flat output slot for output map position (r, c) in an o-wide map.
    function automatic int slot_index(input int r, input int c, input int o);
        return r * o + c;
    endfunction

endpackage

// File: rtl/conv_engine_if.sv
// rtl/conv_engine_if.sv - pixel/weight input and output-map bus for conv_engine
// master: drives in_valid, data_in, weight_value; observes data_out, out_valid
// slave : the engine side
interface conv_engine_if
    import conv_pkg::*;
#(
    parameter int word_length        = WORD_LENGTH,
    parameter int double_word_length = DOUBLE_WORD_LENGTH,
    parameter int kernel_size        = KERNEL_SIZE,
    parameter int image_size         = IMAGE_SIZE
) ();

    localparam int O = image_size - kernel_size + 1;

    logic                                            in_valid;
    logic [kernel_size*kernel_size*word_length-1:0]  weight_value;
    logic [word_length-1:0]                          data_in;
    logic [O*O*double_word_length-1:0]               data_out;
    logic                                            out_valid;

    modport master (
        output in_valid, weight_value, data_in,
        input  data_out, out_valid
    );

    modport slave (
        input  in_valid, weight_value, data_in,
        output data_out, out_valid
    );

endinterface

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - combinational KxK signed multiply-accumulate over one window
// window : K*K signed pixels, element i = ky*K+kx at [W*i +: W]
// weights: K*K signed weights, same layout
// sum    : wrap-around sum of sign-extended products, double_word_length bits
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int word_length        = WORD_LENGTH,
    parameter int double_word_length = DOUBLE_WORD_LENGTH,
    parameter int kernel_size        = KERNEL_SIZE
) (
    input  logic [kernel_size*kernel_size*word_length-1:0] window,
    input  logic [kernel_size*kernel_size*word_length-1:0] weights,
    output logic [double_word_length-1:0]                  sum
);

    localparam int W  = word_length;
    localparam int DW = double_word_length;
    localparam int KK = kernel_size * kernel_size;

    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] acc;

    // Operands are sign-extended to DW first; an unsigned DW x DW product
    // truncated to DW bits is then the exact signed product modulo 2^DW.
    always_comb begin
        a   = '0;
        b   = '0;
        acc = '0;
        for (int i = 0; i < KK; i++) begin
            a   = {{(DW-W){window[i*W + W - 1]}},  window[i*W +: W]};
            b   = {{(DW-W){weights[i*W + W - 1]}}, weights[i*W +: W]};
            acc = acc + a * b;
        end
        sum = acc;
    end

endmodule

// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - streaming 2-D valid convolution producing a flat parallel output map
// clk, rst          : clock, asynchronous active-high reset
// bus.in_valid/data_in : one raster-order pixel per accepted cycle
// bus.weight_value  : static KxK weight set
// bus.data_out      : O*O slots of double_word_length bits, slot r*O+c
// bus.out_valid     : sticky, high once every slot is final
module conv_engine
    import conv_pkg::*;
#(
    parameter int col_length         = 8,
    parameter int word_length        = WORD_LENGTH,
    parameter int double_word_length = DOUBLE_WORD_LENGTH,
    parameter int kernel_size        = KERNEL_SIZE,
    parameter int image_size         = IMAGE_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    conv_engine_if.slave  bus
);

    localparam int K  = kernel_size;
    localparam int N  = image_size;
    localparam int O  = N - K + 1;
    localparam int W  = word_length;
    localparam int DW = double_word_length;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(O*O);

    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] FIRST_OUT = CW'(K - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(O*O - 1);

    // Column grouping is only a hint for physical mapping of the dense array.
    if (col_length < 1) begin : g_col_length_ignored
    end

    conv_state_t          state, state_n;
    logic [CW-1:0]        row, col;
    logic [W-1:0]         lb  [K-1][N];
    logic [W-1:0]         win [K][K];
    logic [K*K*W-1:0]     win_flat;
    logic                 v1, v2;
    logic [SW-1:0]        slot1, slot2;
    logic [DW-1:0]        mac_out, mac_q;
    logic [DW-1:0]        slots [O*O];
    logic [O*O*DW-1:0]    data_out_flat;
    logic                 sample;
    logic                 last_pix;

    assign sample   = bus.in_valid && (state == S_LOAD);
    assign last_pix = (row == LAST_IDX) && (col == LAST_IDX);

    // Stage 0: line buffers, KxK window shift and raster counters.
    // lb[j][c] holds column c of row (R-(K-1)+j) before pixel (R,c) lands,
    // so the newest window column is lb[*][col] stacked over data_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= '0;
            col   <= '0;
            v1    <= 1'b0;
            slot1 <= '0;
            for (int j = 0; j < K-1; j++)
                for (int c = 0; c < N; c++)
                    lb[j][c] <= '0;
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    win[ky][kx] <= '0;
        end else begin
            if (sample) begin
                for (int j = 0; j < K-2; j++)
                    lb[j][col] <= lb[j+1][col];
                lb[K-2][col] <= bus.data_in;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K-1; kx++)
                        win[ky][kx] <= win[ky][kx+1];
                for (int ky = 0; ky < K-1; ky++)
                    win[ky][K-1] <= lb[ky][col];
                win[K-1][K-1] <= bus.data_in;
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // Only windows lying wholly inside one row band produce a slot.
            v1    <= sample && (row >= FIRST_OUT) && (col >= FIRST_OUT);
            slot1 <= SW'(slot_index(int'(row) - (K-1), int'(col) - (K-1), O));
        end
    end

    always_comb begin
        win_flat = '0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                win_flat[(ky*K + kx)*W +: W] = win[ky][kx];
    end

    conv_window_mac #(
        .word_length        (W),
        .double_word_length (DW),
        .kernel_size        (K)
    ) u_mac (
        .window  (win_flat),
        .weights (bus.weight_value),
        .sum     (mac_out)
    );

    // Stage 1 registers the MAC result; stage 2 writes it into its slot.
    // These stages run freely so a stall never holds a finished window back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            slot2 <= '0;
            mac_q <= '0;
            for (int s = 0; s < O*O; s++)
                slots[s] <= '0;
        end else begin
            v2    <= v1;
            slot2 <= slot1;
            mac_q <= mac_out;
            if (v2)
                slots[slot2] <= mac_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_LOAD;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_LOAD:  if (sample && last_pix)             state_n = S_DRAIN;
            S_DRAIN: if (v2 && (slot2 == LAST_SLOT))     state_n = S_DONE;
            S_DONE:                                      state_n = S_DONE;
            default:                                     state_n = S_LOAD;
        endcase
    end

    always_comb begin
        data_out_flat = '0;
        for (int s = 0; s < O*O; s++)
            data_out_flat[s*DW +: DW] = slots[s];
    end

    assign bus.data_out  = data_out_flat;
    assign bus.out_valid = (state == S_DONE);

endmodule

// File: tb/tb_conv_engine.sv
// tb/tb_conv_engine.sv - self-checking bench for conv_engine
module tb_conv_engine;

    localparam int N  = 28;
    localparam int K  = 5;
    localparam int O  = N - K + 1;
    localparam int W  = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_engine_if #(
        .word_length(W), .double_word_length(DW), .kernel_size(K), .image_size(N)
    ) bus ();

    conv_engine #(
        .col_length(8), .word_length(W), .double_word_length(DW),
        .kernel_size(K), .image_size(N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    byte          pix  [N*N];
    byte          wts  [K*K];
    logic [DW-1:0] expv [O*O];

    typedef struct {
        int          wm;
        int          pm;
        int          slot;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // wm: 0 zero, 1 only w[0]=1, 2 all ones, 3 all twos, 4 random
    // pm: 0 random, 1 p mod 128, 2 all ones, 3 all -1
    task automatic build_frame(input int wm, input int pm);
        int acc;
        for (int i = 0; i < K*K; i++) begin
            case (wm)
                0:       wts[i] = 0;
                1:       wts[i] = (i == 0) ? 8'sd1 : 8'sd0;
                2:       wts[i] = 1;
                3:       wts[i] = 2;
                default: wts[i] = byte'($urandom);
            endcase
            bus.weight_value[i*W +: W] = wts[i];
        end
        for (int p = 0; p < N*N; p++) begin
            case (pm)
                0:       pix[p] = byte'($urandom);
                1:       pix[p] = byte'(p % 128);
                2:       pix[p] = 1;
                default: pix[p] = -1;
            endcase
        end
        for (int r = 0; r < O; r++)
            for (int c = 0; c < O; c++) begin
                acc = 0;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += int'(pix[(r+ky)*N + c + kx]) * int'(wts[ky*K + kx]);
                expv[r*O + c] = DW'(acc);
            end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic compare_model(input string name);
        int nbad  = 0;
        int first = -1;
        for (int s = 0; s < O*O; s++)
            if (bus.data_out[s*DW +: DW] !== expv[s]) begin
                nbad++;
                if (first < 0) first = s;
            end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d slots differ, first slot %0d got %0h want %0h",
                     name, nbad, first, bus.data_out[first*DW +: DW], expv[first]);
        end
    endtask

    // Streams pix[] from the current negedge; stall_pct is the chance of a
    // 1-5 cycle in_valid gap before each pixel.
    task automatic run_frame(input string name, input int stall_pct);
        int early = 0;
        int g;
        for (int p = 0; p < N*N; p++) begin
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                g = $urandom_range(5, 1);
                bus.in_valid = 1'b0;
                bus.data_in  = byte'($urandom);
                repeat (g) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b0) early++;
                end
            end
            bus.in_valid = 1'b1;
            bus.data_in  = pix[p];
            @(negedge clk);
            if (bus.out_valid !== 1'b0) early++;
        end
        check({name, "_early_out_valid"}, early, 0);
        // Extra pixels after the last one must be ignored.
        bus.data_in = 8'h7f;
        @(negedge clk);
        check({name, "_out_valid_1edge"}, bus.out_valid, 0);
        @(negedge clk);
        check({name, "_out_valid_2edge"}, bus.out_valid, 1);
        repeat (8) begin
            bus.data_in = byte'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({name, "_out_valid_sticky"}, bus.out_valid, 1);
        compare_model({name, "_map"});
    endtask

    initial begin
        int cur_w = -1;
        int cur_p = -1;

        vecs[0] = '{0, 0, 100, 16'h0000};
        vecs[1] = '{0, 0, 575, 16'h0000};
        vecs[2] = '{1, 1,   0, 16'h0000};
        vecs[3] = '{1, 1,   1, 16'h0001};
        vecs[4] = '{1, 1,  24, 16'h001C};
        vecs[5] = '{1, 1, 575, 16'h001B};
        vecs[6] = '{2, 2,   0, 16'h0019};
        vecs[7] = '{2, 2, 300, 16'h0019};
        vecs[8] = '{3, 3,   0, 16'hFFCE};
        vecs[9] = '{3, 3, 575, 16'hFFCE};

        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.data_in      = '0;
        bus.weight_value = '0;
        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_data_out_nonzero", {31'b0, |bus.data_out}, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wm != cur_w || vecs[i].pm != cur_p) begin
                build_frame(vecs[i].wm, vecs[i].pm);
                apply_reset();
                run_frame($sformatf("frame_w%0d_p%0d", vecs[i].wm, vecs[i].pm), 0);
                cur_w = vecs[i].wm;
                cur_p = vecs[i].pm;
            end
            check($sformatf("vec%0d_slot%0d", i, vecs[i].slot),
                  bus.data_out[vecs[i].slot*DW +: DW], vecs[i].exp);
        end

        // Reset while DONE drops out_valid without waiting for a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("done_reset_out_valid", bus.out_valid, 0);
        check("done_reset_data_out_nonzero", {31'b0, |bus.data_out}, 0);
        @(negedge clk);
        rst = 1'b0;

        build_frame(4, 0);
        apply_reset();
        run_frame("random", 0);

        build_frame(4, 0);
        apply_reset();
        run_frame("stalled", 25);

        // Abort after 300 pixels, then a full frame must match a clean run.
        build_frame(4, 0);
        apply_reset();
        for (int p = 0; p < 300; p++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = byte'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("midframe_reset_out_valid", bus.out_valid, 0);
        check("midframe_reset_data_out_nonzero", {31'b0, |bus.data_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_abort", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
